isp_param_bank: RTL and testbench

- Parametrised ISP parameter register bank with double buffering.
- Bus writes land in shadow registers; `commit` arms a transfer to the active registers, which happens on the next frame boundary (vsync rising edge), so parameters never change mid-frame.
- Adds 1-cycle readback, range checking and a commit timeout.
- Sits between the AHB-side config interface and the ISP pipeline (gain/WB, crop, demosaic, gamma stages).

---
 rtl/isp_cfg_pkg.sv | 26 ++
 rtl/isp_commit_ctrl.sv | 85 ++++++++
 rtl/isp_param_bank.sv | 173 +++++++++++++++++
 tb/tb_isp_param_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/isp_cfg_pkg.sv
// Shared constants for the ISP parameter bank: register map, commit FSM
// encodings and reset defaults.
package isp_cfg_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_MODE   = 4'h1;
    localparam logic [3:0] ADDR_RES    = 4'h3;
    localparam logic [3:0] ADDR_GAIN   = 4'h7;
    localparam logic [3:0] ADDR_GAMMA  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } commit_state_e;

    localparam int DEF_GAIN_RST    = 8;
    localparam int DEF_H_RST       = 1920;
    localparam int DEF_V_RST       = 1080;
    localparam int DEF_TIMEOUT_CYC = 2 ** 20;

    localparam logic [3:0] BAYER_RST = 4'h0;
    localparam logic [2:0] MODE_RST  = 3'h0;
    localparam logic [2:0] GAMMA_RST = 3'b001;

endpackage

// File: rtl/isp_commit_ctrl.sv
// Commit sequencer: waits for the next vsync rising edge (or a timeout)
// before letting the shadow registers be copied to the active set.
//
//   state | meaning
//   IDLE  | no transfer requested
//   ARMED | commit seen, waiting for frame start or timeout
//   APPLY | one cycle; active registers load at the end of it
module isp_commit_ctrl
    import isp_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       commit,
    input  logic       vsync,
    output logic       apply,
    output logic       pending,
    output logic       timeout,
    output logic [1:0] state_code
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    commit_state_e    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_nxt;
    logic             vsync_d;
    logic             frame_start;

    assign frame_start = vsync & ~vsync_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            timeout <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            timeout <= timeout_nxt;
            vsync_d <= vsync;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = timeout;
        unique case (state)
            ST_IDLE: begin
                // a frame edge coinciding with commit only arms
                if (commit) begin
                    state_nxt = ST_ARMED;
                    cnt_nxt   = '0;
                end
            end
            ST_ARMED: begin
                cnt_nxt = cnt + 1'b1;
                if (frame_start) begin
                    state_nxt   = ST_APPLY;
                    timeout_nxt = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_APPLY;
                    timeout_nxt = 1'b1;
                end
            end
            ST_APPLY: begin
                state_nxt = commit ? ST_ARMED : ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign apply      = (state == ST_APPLY);
    assign pending    = (state == ST_ARMED);
    assign state_code = state;

endmodule

// File: rtl/isp_param_bank.sv
// Double-buffered ISP parameter bank: bus writes land in shadow registers
// and reach the pipeline only on a committed frame boundary.
module isp_param_bank
    import isp_cfg_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int GAIN_W      = 8,
    parameter int GAIN_RST    = DEF_GAIN_RST,
    parameter int RES_W       = 12,
    parameter int H_RST       = DEF_H_RST,
    parameter int V_RST       = DEF_V_RST,
    parameter int H_MAX       = 4095,
    parameter int V_MAX       = 4095,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     wr_en,
    input  logic [3:0]               wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    input  logic [3:0]               rd_addr,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    input  logic                     commit,
    input  logic                     vsync,
    output logic [NUM_CH*GAIN_W-1:0] gain_bus,
    output logic [RES_W-1:0]         h_active,
    output logic [RES_W-1:0]         v_active,
    output logic [3:0]               bayer_start,
    output logic [2:0]               isp_mode,
    output logic [2:0]               gamma_coe,
    output logic                     commit_pending,
    output logic                     commit_done,
    output logic                     timeout_flag,
    output logic                     wr_err
);

    localparam int GB_W = NUM_CH * GAIN_W;
    localparam logic [GB_W-1:0]  GAIN_BUS_RST = {NUM_CH{GAIN_W'(GAIN_RST)}};
    localparam logic [RES_W-1:0] H_RST_V      = RES_W'(H_RST);
    localparam logic [RES_W-1:0] V_RST_V      = RES_W'(V_RST);

    logic [GB_W-1:0]  sh_gain, act_gain;
    logic [RES_W-1:0] sh_h, sh_v, act_h, act_v;
    logic [3:0]       sh_bayer, act_bayer;
    logic [2:0]       sh_mode, act_mode;
    logic [2:0]       sh_gamma, act_gamma;

    logic             apply;
    logic [1:0]       state_code;
    logic [RES_W-1:0] wr_h, wr_v;
    logic [31:0]      wr_h_ext, wr_v_ext;
    logic             res_ok;
    logic [31:0]      gain_word, res_word, rd_word;

    isp_commit_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_commit_ctrl (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .commit     (commit),
        .vsync      (vsync),
        .apply      (apply),
        .pending    (commit_pending),
        .timeout    (timeout_flag),
        .state_code (state_code)
    );

    assign wr_h     = wr_data[RES_W-1:0];
    assign wr_v     = wr_data[12 +: RES_W];
    assign wr_h_ext = 32'(wr_h);
    assign wr_v_ext = 32'(wr_v);
    assign res_ok   = (wr_h_ext != 32'd0) && (wr_h_ext <= 32'(H_MAX)) &&
                      (wr_v_ext != 32'd0) && (wr_v_ext <= 32'(V_MAX));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sh_gain  <= GAIN_BUS_RST;
            sh_h     <= H_RST_V;
            sh_v     <= V_RST_V;
            sh_bayer <= BAYER_RST;
            sh_mode  <= MODE_RST;
            sh_gamma <= GAMMA_RST;
            wr_err   <= 1'b0;
        end else begin
            wr_err <= 1'b0;
            if (wr_en) begin
                case (wr_addr)
                    ADDR_MODE:  sh_mode <= wr_data[2:0];
                    ADDR_RES: begin
                        if (res_ok) begin
                            sh_h     <= wr_h;
                            sh_v     <= wr_v;
                            sh_bayer <= wr_data[31:28];
                        end else begin
                            wr_err <= 1'b1;
                        end
                    end
                    ADDR_GAIN: begin
                        // bus word carries ch0 in its MSBs; gain_bus has ch0 in LSBs
                        for (int k = 0; k < NUM_CH; k++)
                            sh_gain[k*GAIN_W +: GAIN_W] <= wr_data[31-k*GAIN_W -: GAIN_W];
                    end
                    ADDR_GAMMA: sh_gamma <= wr_data[2:0];
                    default:    wr_err   <= 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            act_gain  <= GAIN_BUS_RST;
            act_h     <= H_RST_V;
            act_v     <= V_RST_V;
            act_bayer <= BAYER_RST;
            act_mode  <= MODE_RST;
            act_gamma <= GAMMA_RST;
        end else if (apply) begin
            act_gain  <= sh_gain;
            act_h     <= sh_h;
            act_v     <= sh_v;
            act_bayer <= sh_bayer;
            act_mode  <= sh_mode;
            act_gamma <= sh_gamma;
        end
    end

    always_comb begin
        gain_word = '0;
        for (int k = 0; k < NUM_CH; k++)
            gain_word[31-k*GAIN_W -: GAIN_W] = sh_gain[k*GAIN_W +: GAIN_W];
    end

    always_comb begin
        res_word               = '0;
        res_word[RES_W-1:0]    = sh_h;
        res_word[12 +: RES_W]  = sh_v;
        res_word[31:28]        = sh_bayer;
    end

    always_comb begin
        rd_word = '0;
        case (rd_addr)
            ADDR_STATUS: rd_word = {28'b0, timeout_flag, state_code, commit_pending};
            ADDR_MODE:   rd_word = {29'b0, sh_mode};
            ADDR_RES:    rd_word = res_word;
            ADDR_GAIN:   rd_word = gain_word;
            ADDR_GAMMA:  rd_word = {29'b0, sh_gamma};
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= rd_en ? rd_word : 32'd0;
        end
    end

    assign gain_bus    = act_gain;
    assign h_active    = act_h;
    assign v_active    = act_v;
    assign bayer_start = act_bayer;
    assign isp_mode    = act_mode;
    assign gamma_coe   = act_gamma;
    assign commit_done = apply;

endmodule

// File: tb/tb_isp_param_bank.sv
// Directed bench for isp_param_bank: a long-timeout instance for frame
// behaviour and a 16-cycle-timeout instance for the forced apply path.
module tb_isp_param_bank;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'h0;
    logic [31:0] wr_data = 32'h0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = 4'h0;
    logic        commit = 1'b0;
    logic        vsync = 1'b0;

    logic [31:0] rd_data, t_rd_data;
    logic        rd_valid, t_rd_valid;
    logic [23:0] gain_bus, t_gain_bus;
    logic [11:0] h_active, v_active, t_h_active, t_v_active;
    logic [3:0]  bayer_start, t_bayer_start;
    logic [2:0]  isp_mode, gamma_coe, t_isp_mode, t_gamma_coe;
    logic        commit_pending, commit_done, timeout_flag, wr_err;
    logic        t_commit_pending, t_commit_done, t_timeout_flag, t_wr_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    isp_param_bank #(.TIMEOUT_CYC(256)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .commit(commit), .vsync(vsync), .gain_bus(gain_bus),
        .h_active(h_active), .v_active(v_active), .bayer_start(bayer_start),
        .isp_mode(isp_mode), .gamma_coe(gamma_coe), .commit_pending(commit_pending),
        .commit_done(commit_done), .timeout_flag(timeout_flag), .wr_err(wr_err)
    );

    isp_param_bank #(.TIMEOUT_CYC(16)) u_dut_to (
        .HCLK(HCLK), .HRESETn(HRESETn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(t_rd_data),
        .rd_valid(t_rd_valid), .commit(commit), .vsync(vsync), .gain_bus(t_gain_bus),
        .h_active(t_h_active), .v_active(t_v_active), .bayer_start(t_bayer_start),
        .isp_mode(t_isp_mode), .gamma_coe(t_gamma_coe), .commit_pending(t_commit_pending),
        .commit_done(t_commit_done), .timeout_flag(t_timeout_flag), .wr_err(t_wr_err)
    );

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        cyc(1);
        commit = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        cyc(3);
        HRESETn = 1'b1;
        cyc(1);
        n_cmp++; if (gain_bus !== 24'h080808) begin n_err++; $display("FAIL reset_gain: got %h want 080808", gain_bus); end
        n_cmp++; if (h_active !== 12'd1920 || v_active !== 12'd1080) begin n_err++; $display("FAIL reset_res: got %0d/%0d want 1920/1080", h_active, v_active); end
        n_cmp++; if ({gamma_coe, isp_mode, bayer_start} !== {3'd1, 3'd0, 4'd0}) begin n_err++; $display("FAIL reset_misc: got g=%0d m=%0d b=%0d want 1/0/0", gamma_coe, isp_mode, bayer_start); end
        n_cmp++; if ({commit_pending, commit_done, timeout_flag, wr_err, rd_valid} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {commit_pending, commit_done, timeout_flag, wr_err, rd_valid}); end
        rd(4'h0);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin n_err++; $display("FAIL reset_status: got v=%b d=%h want 1/00000000", rd_valid, rd_data); end
        rd(4'h7);
        n_cmp++; if (rd_data !== 32'h08080800) begin n_err++; $display("FAIL reset_gain_rd: got %h want 08080800", rd_data); end
        cyc(1);
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_idle: got %b want 0", rd_valid); end
    endtask

    task automatic test_frame_apply();
        wr(4'h7, 32'h10203000);
        rd(4'h7);
        n_cmp++; if (rd_data !== 32'h10203000) begin n_err++; $display("FAIL gain_rd: got %h want 10203000", rd_data); end
        pulse_commit();
        n_cmp++; if (commit_pending !== 1'b1) begin n_err++; $display("FAIL armed_pending: got %b want 1", commit_pending); end
        cyc(49);
        n_cmp++; if (gain_bus !== 24'h080808 || commit_pending !== 1'b1) begin n_err++; $display("FAIL armed_hold: got %h p=%b want 080808 p=1", gain_bus, commit_pending); end
        vsync = 1'b1;
        cyc(1);
        n_cmp++; if (commit_done !== 1'b1 || gain_bus !== 24'h080808) begin n_err++; $display("FAIL apply_cycle: got done=%b gain=%h want 1/080808", commit_done, gain_bus); end
        cyc(1);
        n_cmp++; if (commit_done !== 1'b0 || gain_bus !== 24'h302010) begin n_err++; $display("FAIL after_apply: got done=%b gain=%h want 0/302010", commit_done, gain_bus); end
        n_cmp++; if (commit_pending !== 1'b0 || timeout_flag !== 1'b0) begin n_err++; $display("FAIL after_apply_flags: got p=%b t=%b want 0/0", commit_pending, timeout_flag); end
        vsync = 1'b0;
        cyc(2);
    endtask

    task automatic test_wr_reject();
        wr(4'h3, 32'h202D0500);
        n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL res_ok_err: got %b want 0", wr_err); end
        wr(4'h3, 32'h102D0000);
        n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL res_h0_err: got %b want 1", wr_err); end
        cyc(1);
        n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL wr_err_pulse: got %b want 0", wr_err); end
        wr(4'h3, 32'h00000500);
        n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL res_v0_err: got %b want 1", wr_err); end
        rd(4'h3);
        n_cmp++; if (rd_data !== 32'h202D0500) begin n_err++; $display("FAIL res_rd: got %h want 202D0500", rd_data); end
        wr(4'h5, 32'hFFFFFFFF);
        n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL bad_addr_err: got %b want 1", wr_err); end
        rd(4'h5);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin n_err++; $display("FAIL bad_addr_rd: got v=%b d=%h want 1/0", rd_valid, rd_data); end
        wr(4'h1, 32'hFFFFFFF5);
        wr(4'hF, 32'h00000003);
        rd(4'h1);
        n_cmp++; if (rd_data !== 32'h5) begin n_err++; $display("FAIL mode_rd: got %h want 5", rd_data); end
        rd(4'hF);
        n_cmp++; if (rd_data !== 32'h3) begin n_err++; $display("FAIL gamma_rd: got %h want 3", rd_data); end
        n_cmp++; if (h_active !== 12'd1920 || isp_mode !== 3'd0) begin n_err++; $display("FAIL no_early_apply: got h=%0d m=%0d want 1920/0", h_active, isp_mode); end
        pulse_commit();
        cyc(5);
        vsync = 1'b1;
        cyc(3);
        vsync = 1'b0;
        n_cmp++; if (h_active !== 12'd1280 || v_active !== 12'd720 || bayer_start !== 4'd2) begin n_err++; $display("FAIL res_apply: got %0d/%0d b=%0d want 1280/720 b=2", h_active, v_active, bayer_start); end
        n_cmp++; if (isp_mode !== 3'd5 || gamma_coe !== 3'd3) begin n_err++; $display("FAIL mode_gamma_apply: got m=%0d g=%0d want 5/3", isp_mode, gamma_coe); end
        cyc(20);
    endtask

    task automatic test_timeout();
        n_cmp++; if (t_timeout_flag !== 1'b0 || t_commit_pending !== 1'b0) begin n_err++; $display("FAIL to_pre: got t=%b p=%b want 0/0", t_timeout_flag, t_commit_pending); end
        pulse_commit();
        cyc(15);
        n_cmp++; if (t_commit_pending !== 1'b1 || t_commit_done !== 1'b0) begin n_err++; $display("FAIL to_still_armed: got p=%b d=%b want 1/0", t_commit_pending, t_commit_done); end
        cyc(1);
        n_cmp++; if (t_commit_done !== 1'b1 || t_timeout_flag !== 1'b1) begin n_err++; $display("FAIL to_apply: got d=%b t=%b want 1/1", t_commit_done, t_timeout_flag); end
        cyc(1);
        n_cmp++; if (t_commit_done !== 1'b0 || t_timeout_flag !== 1'b1) begin n_err++; $display("FAIL to_sticky: got d=%b t=%b want 0/1", t_commit_done, t_timeout_flag); end
        rd(4'h0);
        n_cmp++; if (t_rd_data !== 32'h8) begin n_err++; $display("FAIL to_status: got %h want 8", t_rd_data); end
        n_cmp++; if (rd_data !== 32'h3) begin n_err++; $display("FAIL armed_status: got %h want 3", rd_data); end
        pulse_commit();
        cyc(2);
        vsync = 1'b1;
        cyc(1);
        n_cmp++; if (t_commit_done !== 1'b1 || commit_done !== 1'b1) begin n_err++; $display("FAIL frame_apply_both: got t=%b m=%b want 1/1", t_commit_done, commit_done); end
        cyc(1);
        n_cmp++; if (t_timeout_flag !== 1'b0) begin n_err++; $display("FAIL to_cleared: got %b want 0", t_timeout_flag); end
        vsync = 1'b0;
        cyc(20);
    endtask

    task automatic test_simultaneous();
        wr(4'h7, 32'hAABBCC00);
        commit = 1'b1;
        vsync = 1'b1;
        cyc(1);
        commit = 1'b0;
        n_cmp++; if (commit_pending !== 1'b1 || commit_done !== 1'b0) begin n_err++; $display("FAIL sim_arm: got p=%b d=%b want 1/0", commit_pending, commit_done); end
        cyc(3);
        n_cmp++; if (commit_pending !== 1'b1 || gain_bus !== 24'h302010) begin n_err++; $display("FAIL sim_hold: got p=%b gain=%h want 1/302010", commit_pending, gain_bus); end
        vsync = 1'b0;
        cyc(2);
        vsync = 1'b1;
        cyc(1);
        n_cmp++; if (commit_done !== 1'b1) begin n_err++; $display("FAIL sim_apply: got %b want 1", commit_done); end
        wr(4'h7, 32'h11223300);
        n_cmp++; if (gain_bus !== 24'hCCBBAA || commit_done !== 1'b0) begin n_err++; $display("FAIL apply_race_gain: got %h d=%b want CCBBAA/0", gain_bus, commit_done); end
        rd(4'h7);
        n_cmp++; if (rd_data !== 32'h11223300) begin n_err++; $display("FAIL apply_race_rd: got %h want 11223300", rd_data); end
        vsync = 1'b0;
        cyc(3);
        n_cmp++; if (gain_bus !== 24'hCCBBAA || commit_pending !== 1'b0) begin n_err++; $display("FAIL apply_race_idle: got %h p=%b want CCBBAA/0", gain_bus, commit_pending); end
    endtask

    task automatic test_reset_mid();
        wr(4'h7, 32'h55667700);
        pulse_commit();
        n_cmp++; if (commit_pending !== 1'b1) begin n_err++; $display("FAIL rst_pre_armed: got %b want 1", commit_pending); end
        HRESETn = 1'b0;
        #2;
        n_cmp++; if (commit_pending !== 1'b0 || gain_bus !== 24'h080808 || h_active !== 12'd1920) begin n_err++; $display("FAIL rst_async: got p=%b gain=%h h=%0d want 0/080808/1920", commit_pending, gain_bus, h_active); end
        cyc(2);
        HRESETn = 1'b1;
        cyc(2);
        vsync = 1'b1;
        cyc(1);
        n_cmp++; if (commit_done !== 1'b0) begin n_err++; $display("FAIL rst_no_apply: got %b want 0", commit_done); end
        cyc(2);
        vsync = 1'b0;
        n_cmp++; if (gain_bus !== 24'h080808 || commit_pending !== 1'b0) begin n_err++; $display("FAIL rst_after: got %h p=%b want 080808/0", gain_bus, commit_pending); end
        rd(4'h7);
        n_cmp++; if (rd_data !== 32'h08080800) begin n_err++; $display("FAIL rst_shadow_rd: got %h want 08080800", rd_data); end
    endtask

    initial begin
        test_reset();
        test_frame_apply();
        test_wr_reject();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
